// File: rtl/fp_pkg.sv
// ---------------------------------------------------------------------------
// fp_pkg
// Shared definitions for the floating-point mantissa normalizer: FSM state
// encoding and the coarse left-shift step size.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fp_pkg;

  // Normalizer control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Shift distance used when the four leading mantissa bits are all clear
  localparam int COARSE_STEP = 4;

endpackage : fp_pkg

`default_nettype wire

// File: rtl/fp_normalizer_norm_step.sv
// ---------------------------------------------------------------------------
// norm_step
// One combinational normalization step: left-shifts the mantissa by k and
// decrements the exponent by the same k.
// Build option: FP_NORMALIZER_COARSE_SHIFT_EN enables k=4 steps when the
// four leading bits are zero and the exponent can absorb the full step.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module norm_step
  import fp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int EXP_W = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] mant_i,
  input  logic [EXP_W-1:0] exp_i,
  output logic [WIDTH-1:0] mant_o,
  output logic [EXP_W-1:0] exp_o,
  output logic [SHW-1:0]   k_o
);

  // Choose the step size, then apply it to mantissa and exponent together
  always_comb begin
    k_o = SHW'(1);
`ifdef FP_NORMALIZER_COARSE_SHIFT_EN
    // A 4-bit jump is safe only if none of the intermediate single steps
    // would have stopped: the leading nibble is zero (mantissa stays
    // nonzero, MSB stays clear) and the exponent does not hit zero early.
    if ((mant_i[WIDTH-1 -: COARSE_STEP] == '0) &&
        (exp_i >= EXP_W'(COARSE_STEP))) begin
      k_o = SHW'(COARSE_STEP);
    end
`endif
    mant_o = mant_i << k_o;
    exp_o  = exp_i - EXP_W'(k_o);
  end

endmodule : norm_step

`default_nettype wire

// File: rtl/fp_normalizer.sv
// ---------------------------------------------------------------------------
// fp_normalizer
// Iterative left-normalizer for an unnormalized mantissa/exponent pair.
// Accepts one operand in IDLE, shifts until the hidden-bit position is set,
// the mantissa is zero, or the exponent reaches zero, then holds the result
// until the consumer takes it.
// Build option: FP_NORMALIZER_COARSE_SHIFT_EN (4-bit coarse stepping).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fp_normalizer
  import fp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int EXP_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_mant,
  input  logic [EXP_W-1:0]          in_exp,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_mant,
  output logic [EXP_W-1:0]          out_exp,
  output logic [$clog2(WIDTH)-1:0]  out_shift,
  output logic                      out_zero,
  output logic                      out_denorm
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state_q, state_d;

  logic [WIDTH-1:0] mant_q, mant_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [SHW-1:0]   shift_q, shift_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_mant_q, out_mant_d;
  logic [EXP_W-1:0] out_exp_q, out_exp_d;
  logic [SHW-1:0]   out_shift_q, out_shift_d;
  logic             out_zero_q, out_zero_d;
  logic             out_denorm_q, out_denorm_d;

  logic [WIDTH-1:0] step_mant;
  logic [EXP_W-1:0] step_exp;
  logic [SHW-1:0]   step_k;

  logic             mant_is_zero;
  logic             stop_shift;
  logic             accept;
  logic             consume;

  norm_step #(
    .WIDTH (WIDTH),
    .EXP_W (EXP_W),
    .SHW   (SHW)
  ) u_step (
    .mant_i (mant_q),
    .exp_i  (exp_q),
    .mant_o (step_mant),
    .exp_o  (step_exp),
    .k_o    (step_k)
  );

  assign mant_is_zero = (mant_q == '0);
  assign stop_shift   = mant_is_zero || mant_q[WIDTH-1] || (exp_q == '0);
  assign in_ready     = (state_q == IDLE);
  assign accept       = in_valid && in_ready;
  assign consume      = out_valid_q && out_ready;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)     state_d = SHIFT;
      SHIFT:   if (stop_shift) state_d = DONE;
      DONE:    if (consume)    state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Working-register and result next-state logic
  always_comb begin
    mant_d       = mant_q;
    exp_d        = exp_q;
    shift_d      = shift_q;
    out_valid_d  = out_valid_q;
    out_mant_d   = out_mant_q;
    out_exp_d    = out_exp_q;
    out_shift_d  = out_shift_q;
    out_zero_d   = out_zero_q;
    out_denorm_d = out_denorm_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          mant_d  = in_mant;
          exp_d   = in_exp;
          shift_d = '0;
        end
      end
      SHIFT: begin
        if (!stop_shift) begin
          mant_d  = step_mant;
          exp_d   = step_exp;
          shift_d = shift_q + step_k;
        end
      end
      DONE: begin
        // First DONE cycle publishes the result; later cycles only hold it
        if (!out_valid_q) begin
          out_valid_d  = 1'b1;
          out_mant_d   = mant_q;
          out_exp_d    = mant_is_zero ? '0 : exp_q;
          out_shift_d  = shift_q;
          out_zero_d   = mant_is_zero;
          out_denorm_d = !mant_is_zero && !mant_q[WIDTH-1];
        end else if (out_ready) begin
          out_valid_d  = 1'b0;
        end
      end
      default: begin
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Working and result registers; reset discards any in-flight operand
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mant_q       <= '0;
      exp_q        <= '0;
      shift_q      <= '0;
      out_valid_q  <= 1'b0;
      out_mant_q   <= '0;
      out_exp_q    <= '0;
      out_shift_q  <= '0;
      out_zero_q   <= 1'b0;
      out_denorm_q <= 1'b0;
    end else begin
      mant_q       <= mant_d;
      exp_q        <= exp_d;
      shift_q      <= shift_d;
      out_valid_q  <= out_valid_d;
      out_mant_q   <= out_mant_d;
      out_exp_q    <= out_exp_d;
      out_shift_q  <= out_shift_d;
      out_zero_q   <= out_zero_d;
      out_denorm_q <= out_denorm_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_mant   = out_mant_q;
  assign out_exp    = out_exp_q;
  assign out_shift  = out_shift_q;
  assign out_zero   = out_zero_q;
  assign out_denorm = out_denorm_q;

endmodule : fp_normalizer

`default_nettype wire

// File: tb/tb_fp_normalizer.sv
// ---------------------------------------------------------------------------
// tb_fp_normalizer
// Directed and randomized checks of fp_normalizer against a reference model
// that normalizes with plain arithmetic.
// Build option: FP_NORMALIZER_COARSE_SHIFT_EN selects the coarse latency model.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fp_normalizer;

  localparam int WIDTH = 16;
  localparam int EXP_W = 8;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_mant;
  logic [EXP_W-1:0]  in_exp;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_mant;
  logic [EXP_W-1:0]  out_exp;
  logic [3:0]        out_shift;
  logic              out_zero;
  logic              out_denorm;

  int errors = 0;
  int checks = 0;

  fp_normalizer #(.WIDTH(WIDTH), .EXP_W(EXP_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mant    (in_mant),
    .in_exp     (in_exp),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_mant   (out_mant),
    .out_exp    (out_exp),
    .out_shift  (out_shift),
    .out_zero   (out_zero),
    .out_denorm (out_denorm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference: normalize one bit at a time from the rules; latency follows
  // the step size the build uses.
  task automatic model(input logic [15:0] m, input logic [7:0] e,
                       output logic [15:0] xm, output logic [7:0] xe,
                       output logic [3:0] xs, output bit xz, output bit xd,
                       output int lat);
    int mm, ee, s, steps, k;
    mm = m; ee = e; s = 0; steps = 0;
    while (mm != 0 && mm < 32768 && ee > 0) begin
      k = 1;
`ifdef FP_NORMALIZER_COARSE_SHIFT_EN
      if (mm < 4096 && ee >= 4) k = 4;
`endif
      mm = (mm * (2 ** k)) % 65536;
      ee = ee - k;
      s  = s + k;
      steps++;
    end
    xz  = (mm == 0);
    xd  = (mm != 0) && (mm < 32768);
    xm  = 16'(mm);
    xe  = xz ? 8'd0 : 8'(ee);
    xs  = 4'(s);
    lat = 2 + steps;
  endtask

  task automatic run_op(input logic [15:0] m, input logic [7:0] e,
                        input logic [15:0] xm, input logic [7:0] xe,
                        input logic [3:0] xs, input bit xz, input bit xd,
                        input int xlat, input int hold);
    int cyc;
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("ready_before_op", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_mant  = m;
    in_exp   = e;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
    cyc = 0;
    while (cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      if (out_valid) break;
    end
    check("latency", cyc, xlat);
    check("out_mant", out_mant, xm);
    check("out_exp", out_exp, xe);
    check("out_shift", out_shift, xs);
    check("out_zero", out_zero, xz);
    check("out_denorm", out_denorm, xd);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_mant  = 16'($urandom);
      in_exp   = 8'($urandom);
      @(posedge clk);
      #1;
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_mant", out_mant, xm);
      check("hold_exp", out_exp, xe);
      check("hold_flags", {out_shift, out_zero, out_denorm}, {xs, xz, xd});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("consume_valid", {31'd0, out_valid}, 32'd0);
    check("consume_ready", {31'd0, in_ready}, 32'd1);
    check("consume_hold_mant", out_mant, xm);
  endtask

  logic [15:0] rm, xm;
  logic [7:0]  re, xe;
  logic [3:0]  xs;
  bit          xz, xd;
  int          xlat;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mant   = '0;
    in_exp    = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_outputs", {out_mant, out_exp, out_shift, out_zero, out_denorm}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Already normalized
    run_op(16'hB252, 8'd10, 16'hB252, 8'd10, 4'd0, 1'b0, 1'b0, 2, 0);
    // Maximum shift distance
`ifdef FP_NORMALIZER_COARSE_SHIFT_EN
    run_op(16'h0001, 8'd20, 16'h8000, 8'd5, 4'd15, 1'b0, 1'b0, 8, 0);
`else
    run_op(16'h0001, 8'd20, 16'h8000, 8'd5, 4'd15, 1'b0, 1'b0, 17, 0);
`endif
    // Zero mantissa
    run_op(16'h0000, 8'd37, 16'h0000, 8'd0, 4'd0, 1'b1, 1'b0, 2, 0);
    // Exponent exhausted before normalization
    run_op(16'h0010, 8'd2, 16'h0040, 8'd0, 4'd2, 1'b0, 1'b1, 4, 0);
    // Consumer stalls five cycles
    model(16'h0123, 8'd9, xm, xe, xs, xz, xd, xlat);
    run_op(16'h0123, 8'd9, xm, xe, xs, xz, xd, xlat, 5);

    // Reset mid-SHIFT discards the operand
    @(negedge clk);
    in_valid = 1'b1;
    in_mant  = 16'h0001;
    in_exp   = 8'd20;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_outputs", {out_mant, out_exp, out_shift, out_zero, out_denorm}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("postrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("postrst_out_valid", {31'd0, out_valid}, 32'd0);

    // Randomized operands with a spread of leading-zero counts and exponents
    for (int i = 0; i < 40; i++) begin
      rm = 16'($urandom >> $urandom_range(16, 31));
      re = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 5)) : 8'($urandom);
      model(rm, re, xm, xe, xs, xz, xd, xlat);
      run_op(rm, re, xm, xe, xs, xz, xd, xlat, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule : tb_fp_normalizer

`default_nettype wire

// File: doc/fp_normalizer.md
FP_NORMALIZER -- requirements
Module: fp_normalizer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the mantissa width in bits.
REQ-002 SHALL have parameter EXP_W, default 8, giving the biased exponent width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  the operand on in_mant/in_exp is valid.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand (IDLE only).
REQ-007 SHALL have port in_mant  input  WIDTH  unnormalized mantissa, MSB is the hidden-bit position.
REQ-008 SHALL have port in_exp  input  EXP_W  unsigned exponent of the operand.
REQ-009 SHALL have port out_valid  output  1  result registers hold a finished result.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port out_mant  output  WIDTH  left-normalized mantissa.
REQ-012 SHALL have port out_exp  output  EXP_W  in_exp minus total shift.
REQ-013 SHALL have port out_shift  output  $clog2(WIDTH)  total left-shift applied.
REQ-014 SHALL have port out_zero  output  1  input mantissa was zero.
REQ-015 SHALL have port out_denorm  output  1  shifting stopped because the exponent reached 0 with MSB still clear.

Function
REQ-016 SHALL implement FSM IDLE -> SHIFT -> DONE -> IDLE.
REQ-017 SHALL assert in_ready only in IDLE; on in_valid&&in_ready, capture mantissa/exponent, clear shift count, go to SHIFT.
REQ-018 In SHIFT, SHALL go to DONE when mant==0 (set zero, force exp=0), mant[MSB]==1, or exp==0 (set denorm if mant[MSB]==0).
REQ-019 Otherwise in SHIFT, SHALL shift mant left by k, fill zeros, exp-=k, shift+=k, and remain in SHIFT; k=1 in the base build.
REQ-020 SHALL hold out_valid high in DONE with all outputs stable until out_ready; on out_valid&&out_ready return to IDLE.
REQ-021 Latency, base build: out_valid rises 2+L cycles after the accept edge, L = shifts performed (0..WIDTH-1).
REQ-022 SHALL never accept a new operand while SHIFT or DONE; no bypass from in to out.
REQ-023 out_* SHALL be registered; out_mant/out_exp/out_shift/flags SHALL be don't-care-free (hold last values) when out_valid=0.

Reset
REQ-024 On rst_n low, SHALL enter IDLE immediately, including mid-SHIFT or in DONE, discarding any in-flight operand.
REQ-025 Reset values: in_ready=1 after release, out_valid=0, out_mant=0, out_exp=0, out_shift=0, out_zero=0, out_denorm=0.

Configuration
REQ-026 Macro FP_NORMALIZER_COARSE_SHIFT_EN SHALL select coarse stepping: k=4 when mant[MSB:MSB-3]==0 and exp>=4, else k=1; latency 2+floor(L/4)+(L mod 4) when exp does not limit.
REQ-027 Without the macro, k SHALL be 1 every SHIFT cycle; results SHALL be bit-identical in both builds.

Structure
REQ-028 SHALL place the FSM state enum (IDLE, SHIFT, DONE) and the coarse step constant 4 in shared package fp_pkg.
REQ-029 SHALL isolate the per-cycle shift/decrement step in a sub-module norm_step (combinational: mant, exp -> next mant, exp, k).

Verification
REQ-030 in_mant=0xB252, in_exp=10 -> out_mant=0xB252, out_exp=10, out_shift=0, flags 0, out_valid 2 cycles after accept.
REQ-031 in_mant=0x0001, in_exp=20 -> out_mant=0x8000, out_exp=5, out_shift=15; out_valid after 17 cycles (base) / 8 cycles (coarse).
REQ-032 in_mant=0x0000, in_exp=37 -> out_zero=1, out_mant=0, out_exp=0, out_shift=0, out_denorm=0.
REQ-033 in_mant=0x0010, in_exp=2 -> out_mant=0x0040, out_exp=0, out_shift=2, out_denorm=1.
REQ-034 out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0 throughout; rst_n pulsed mid-SHIFT -> out_valid=0, in_ready=1 after release.
